// File: rtl/pc_stack_if.sv
// rtl/pc_stack_if.sv - command/status bundle between the fetch control and pc_stack_unit
//
// Purpose: groups the pc unit's command strobes, operands and status outputs.
// Signals:
//   stall, ld_pc, pc_inc, branch, call, ret   command strobes (master -> slave)
//   add[AW], offset[OW]                      jump/call target, signed branch offset
//   pc[AW], exec_add[AW]                     fetch address and its one-cycle-delayed copy
//   sp[$clog2(DEPTH+1)]                      return-stack occupancy
//   stk_full, stk_empty, err                 stack status and sticky fault flag
// Modports: master drives commands and observes status; slave is the pc unit.
interface pc_stack_if #(
    parameter int AW    = 12,
    parameter int OW    = 8,
    parameter int DEPTH = 4
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic          stall;
    logic          ld_pc;
    logic          pc_inc;
    logic          branch;
    logic          call;
    logic          ret;
    logic [AW-1:0] add;
    logic [OW-1:0] offset;
    logic [AW-1:0] pc;
    logic [AW-1:0] exec_add;
    logic [SPW-1:0] sp;
    logic          stk_full;
    logic          stk_empty;
    logic          err;

    modport master (
        output stall, ld_pc, pc_inc, branch, call, ret, add, offset,
        input  pc, exec_add, sp, stk_full, stk_empty, err
    );

    modport slave (
        input  stall, ld_pc, pc_inc, branch, call, ret, add, offset,
        output pc, exec_add, sp, stk_full, stk_empty, err
    );
endinterface

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with relative branch, stall and return-address stack
//
// Purpose: produces the fetch address (pc) and its one-cycle-delayed copy (exec_add),
// executes one command per edge with priority ret > call > ld_pc > branch > pc_inc,
// and keeps a DEPTH-entry hardware return stack with sticky overflow/underflow fault.
// Ports:
//   clock   rising-edge clock
//   reset   synchronous, active-high; pc/exec_add <= RESET_ADDR, sp <= 0, err <= 0
//   bus     pc_stack_if.slave: command strobes/operands in, pc/exec_add/sp/status out
module pc_stack_unit #(
    parameter int AW         = 12,
    parameter int OW         = 8,
    parameter int DEPTH      = 4,
    parameter int RESET_ADDR = 0
) (
    input  logic     clock,
    input  logic     reset,
    pc_stack_if.slave bus
);
    localparam int SPW = $clog2(DEPTH + 1);
    // Index width for the stack array; sp itself needs one extra code for "full".
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
    localparam logic [AW-1:0]  PC_RESET = AW'(RESET_ADDR);

    logic [AW-1:0]  stack [2**IW];
    logic [AW-1:0]  pc_q, exec_q, pc_n, off_ext, ret_addr;
    logic [SPW-1:0] sp_q, sp_n, sp_dec;
    logic           err_q, err_n, push;

    assign off_ext  = AW'($signed(bus.offset));
    assign ret_addr = pc_q + AW'(1);
    assign sp_dec   = sp_q - SPW'(1);

    always_comb begin
        pc_n  = pc_q;
        sp_n  = sp_q;
        err_n = err_q;
        push  = 1'b0;
        if (bus.ret) begin
            if (sp_q != '0) begin
                pc_n = stack[sp_dec[IW-1:0]];
                sp_n = sp_dec;
            end else begin
                err_n = 1'b1;
            end
        end else if (bus.call) begin
            if (sp_q != SP_FULL) begin
                push = 1'b1;
                pc_n = bus.add;
                sp_n = sp_q + SPW'(1);
            end else begin
                err_n = 1'b1;
            end
        end else if (bus.ld_pc) begin
            pc_n = bus.add;
        end else if (bus.branch) begin
            pc_n = pc_q + off_ext;
        end else if (bus.pc_inc) begin
            pc_n = ret_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q   <= PC_RESET;
            exec_q <= PC_RESET;
            sp_q   <= '0;
            err_q  <= 1'b0;
        end else if (!bus.stall) begin
            pc_q   <= pc_n;
            exec_q <= pc_q;
            sp_q   <= sp_n;
            err_q  <= err_n;
        end
    end

    // Stack contents are not reset; only sp defines which entries are live.
    always_ff @(posedge clock) begin
        if (!reset && !bus.stall && push) begin
            stack[sp_q[IW-1:0]] <= ret_addr;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.exec_add  = exec_q;
    assign bus.sp        = sp_q;
    assign bus.stk_full  = (sp_q == SP_FULL);
    assign bus.stk_empty = (sp_q == '0);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - scoreboard testbench for pc_stack_unit
module tb_pc_stack_unit;
    localparam int AW = 12, OW = 8, DEPTH = 4;
    localparam int MODV = 1 << AW;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pc_stack_if #(.AW(AW), .OW(OW), .DEPTH(DEPTH)) bus ();

    pc_stack_unit #(.AW(AW), .OW(OW), .DEPTH(DEPTH), .RESET_ADDR(0)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        int pc;
        int ex;
        int sp;
        int full;
        int empty;
        int err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_pc = 0, m_ex = 0, m_err = 0;
    int m_stk[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, req);
        end
    endtask

    // Monitor: one expected state per clock edge, sampled 1 time unit after it.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("pc",        int'(bus.pc),        mon_e.pc);
            chk("exec_add",  int'(bus.exec_add),  mon_e.ex);
            chk("sp",        int'(bus.sp),        mon_e.sp);
            chk("stk_full",  int'(bus.stk_full),  mon_e.full);
            chk("stk_empty", int'(bus.stk_empty), mon_e.empty);
            chk("err",       int'(bus.err),       mon_e.err);
        end
    end

    task automatic drive(input bit rst, input bit st, input bit ld, input bit inc,
                         input bit br, input bit cl, input bit rt,
                         input int a, input int off);
        int   old;
        int   soff;
        exp_t e;
        @(negedge clock);
        reset      = rst;
        bus.stall  = st;
        bus.ld_pc  = ld;
        bus.pc_inc = inc;
        bus.branch = br;
        bus.call   = cl;
        bus.ret    = rt;
        bus.add    = AW'(a);
        bus.offset = OW'(off);
        if (rst) begin
            m_pc = 0; m_ex = 0; m_err = 0;
            m_stk.delete();
        end else if (!st) begin
            old = m_pc;
            if (rt) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else m_err = 1;
            end else if (cl) begin
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back((m_pc + 1) % MODV);
                    m_pc = a % MODV;
                end else m_err = 1;
            end else if (ld) begin
                m_pc = a % MODV;
            end else if (br) begin
                soff = (off % 256 >= 128) ? (off % 256) - 256 : off % 256;
                m_pc = (m_pc + soff + MODV) % MODV;
            end else if (inc) begin
                m_pc = (m_pc + 1) % MODV;
            end
            m_ex = old;
        end
        e.pc    = m_pc;
        e.ex    = m_ex;
        e.sp    = m_stk.size();
        e.full  = (m_stk.size() == DEPTH) ? 1 : 0;
        e.empty = (m_stk.size() == 0) ? 1 : 0;
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    // Argument order: rst, stall, ld_pc, pc_inc, branch, call, ret, add, offset
    initial begin
        reset = 1'b1;
        bus.stall = 0; bus.ld_pc = 0; bus.pc_inc = 0; bus.branch = 0;
        bus.call = 0; bus.ret = 0; bus.add = '0; bus.offset = '0;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // wrap on increment, backward branch wrap
        drive(0, 0, 1, 0, 0, 0, 0, 'hFFF, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 'h002, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 'hFC);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 'h05);
        // call/ret pair
        drive(0, 0, 1, 0, 0, 0, 0, 'h010, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 'h200, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        // overflow and underflow
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) drive(0, 0, 0, 0, 0, 1, 0, 'h100, 0);
        repeat (5) drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        // stall drops commands; priority ret over call/pc_inc
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 'h050, 0);
        repeat (3) drive(0, 1, 0, 1, 0, 1, 0, 'h300, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 'h300, 0);
        drive(0, 0, 0, 1, 0, 1, 1, 'h400, 0);
        // reset beats call at sp=2
        drive(0, 0, 0, 0, 0, 1, 0, 'h123, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 'h234, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 'h345, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, MODV - 1)), int'($urandom_range(0, 255)));
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
